// File: rtl/gain_ramp_ctrl.sv
// Gain coefficient sequencer for the real-by-complex gain multiplier.
// Gain slews toward a programmed target by a fixed step per observed stream beat.
module gain_ramp_ctrl #(
   parameter int unsigned            GAIN_WIDTH = 16,
   parameter logic [7:0]             SR_TARGET  = 8'd192,
   parameter logic [7:0]             SR_STEP    = 8'd193,
   parameter logic [7:0]             SR_CTRL    = 8'd194,
   parameter logic [GAIN_WIDTH-1:0]  RESET_GAIN = 16'h0100
) (
   input  logic                   ce_clk,
   input  logic                   ce_rst_n,
   input  logic                   set_stb,
   input  logic [7:0]             set_addr,
   input  logic [31:0]            set_data,
   input  logic                   smp_tvalid,
   input  logic                   smp_tready,
   input  logic                   smp_tlast,
   output logic [GAIN_WIDTH-1:0]  gain_out,
   output logic                   ramping,
   output logic                   pending,
   output logic [63:0]            rb_data
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PENDING = 2'd1,
      S_RAMP    = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [GAIN_WIDTH-1:0]   target, target_nxt;
   logic [GAIN_WIDTH-1:0]   step, step_nxt;
   logic [GAIN_WIDTH-1:0]   gain_nxt;
   logic                    sync_on_eop, sync_nxt;
   logic [63:0]             rb_nxt;

   logic                    beat;
   logic                    wr_target, wr_step, wr_ctrl, abort;
   logic [GAIN_WIDTH-1:0]   wr_val;

   // One step toward tgt, clamped so it can neither overshoot nor wrap.
   function automatic logic [GAIN_WIDTH-1:0] ramp_toward(
      input logic [GAIN_WIDTH-1:0] cur,
      input logic [GAIN_WIDTH-1:0] tgt,
      input logic [GAIN_WIDTH-1:0] stp
   );
      logic signed [GAIN_WIDTH:0] diff;
      logic        [GAIN_WIDTH:0] mag;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      mag  = diff[GAIN_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      if (stp == '0 || mag <= {1'b0, stp})
         return tgt;
      else if (diff[GAIN_WIDTH])
         return cur - stp;
      else
         return cur + stp;
   endfunction

   function automatic logic [63:0] rb_pack(
      input logic [GAIN_WIDTH-1:0] s,
      input logic [GAIN_WIDTH-1:0] t,
      input logic [GAIN_WIDTH-1:0] g
   );
      logic [63:0] r;
      r = '0;
      r[GAIN_WIDTH-1:0]     = g;
      r[16 +: GAIN_WIDTH]   = t;
      r[32 +: GAIN_WIDTH]   = s;
      return r;
   endfunction

   assign beat      = smp_tvalid & smp_tready;
   assign wr_target = set_stb && (set_addr == SR_TARGET);
   assign wr_step   = set_stb && (set_addr == SR_STEP);
   assign wr_ctrl   = set_stb && (set_addr == SR_CTRL);
   assign abort     = wr_ctrl & set_data[1];
   assign wr_val    = set_data[GAIN_WIDTH-1:0];

   always_comb begin
      state_nxt  = state;
      gain_nxt   = gain_out;
      target_nxt = target;
      step_nxt   = step;
      sync_nxt   = sync_on_eop;

      if (wr_step)
         step_nxt = wr_val;
      if (wr_ctrl)
         sync_nxt = set_data[0];

      if (abort) begin
         state_nxt  = S_IDLE;
         target_nxt = gain_out;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (wr_target) begin
                  target_nxt = wr_val;
                  if (wr_val != gain_out)
                     state_nxt = sync_on_eop ? S_PENDING : S_RAMP;
               end
            end
            S_PENDING: begin
               if (wr_target)
                  target_nxt = wr_val;
               // The tlast beat only arms the ramp; stepping begins with the next beat.
               if (wr_target && wr_val == gain_out)
                  state_nxt = S_IDLE;
               else if (beat && smp_tlast)
                  state_nxt = S_RAMP;
            end
            S_RAMP: begin
               // A beat coinciding with a retarget still steps toward the old target.
               if (beat)
                  gain_nxt = ramp_toward(gain_out, target, step);
               if (wr_target)
                  target_nxt = wr_val;
               if (gain_nxt == target_nxt)
                  state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end

      rb_nxt = rb_pack(step_nxt, target_nxt, gain_nxt);
   end

   always_ff @(posedge ce_clk or negedge ce_rst_n) begin
      if (!ce_rst_n) begin
         state       <= S_IDLE;
         gain_out    <= RESET_GAIN;
         target      <= RESET_GAIN;
         step        <= '0;
         sync_on_eop <= 1'b0;
         ramping     <= 1'b0;
         pending     <= 1'b0;
         rb_data     <= rb_pack('0, RESET_GAIN, RESET_GAIN);
      end else begin
         state       <= state_nxt;
         gain_out    <= gain_nxt;
         target      <= target_nxt;
         step        <= step_nxt;
         sync_on_eop <= sync_nxt;
         ramping     <= (state_nxt == S_RAMP);
         pending     <= (state_nxt == S_PENDING);
         rb_data     <= rb_nxt;
      end
   end

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Bench for gain_ramp_ctrl: directed scenarios plus randomized traffic against
// an arithmetic reference model of the ramp rules.
module tb_gain_ramp_ctrl;

   logic        ce_clk = 1'b0;
   logic        ce_rst_n = 1'b0;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = '0;
   logic [31:0] set_data = '0;
   logic        smp_tvalid = 1'b0;
   logic        smp_tready = 1'b0;
   logic        smp_tlast = 1'b0;
   logic [15:0] gain_out;
   logic        ramping;
   logic        pending;
   logic [63:0] rb_data;

   gain_ramp_ctrl dut (
      .ce_clk     (ce_clk),
      .ce_rst_n   (ce_rst_n),
      .set_stb    (set_stb),
      .set_addr   (set_addr),
      .set_data   (set_data),
      .smp_tvalid (smp_tvalid),
      .smp_tready (smp_tready),
      .smp_tlast  (smp_tlast),
      .gain_out   (gain_out),
      .ramping    (ramping),
      .pending    (pending),
      .rb_data    (rb_data)
   );

   always #5 ce_clk = ~ce_clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: plain integers and two mode flags.
   int m_g, m_t, m_s;
   bit m_sync, m_ramp, m_pend;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int toward(input int g, input int t, input int s);
      int d;
      d = t - g;
      if (d < 0) d = -d;
      if (s == 0 || d <= s) return t;
      return (t > g) ? g + s : g - s;
   endfunction

   task automatic model_reset();
      m_g = 'h100; m_t = 'h100; m_s = 0;
      m_sync = 0; m_ramp = 0; m_pend = 0;
   endtask

   task automatic check_outputs(input string tag);
      logic [63:0] rb_exp;
      rb_exp = {16'd0, 16'(m_s), 16'(m_t), 16'(m_g)};
      chk({tag, "_gain"}, 64'(gain_out), 64'(m_g));
      chk({tag, "_ramping"}, 64'(ramping), 64'(m_ramp));
      chk({tag, "_pending"}, 64'(pending), 64'(m_pend));
      chk({tag, "_rb"}, rb_data, rb_exp);
   endtask

   // Advance one clock: predict from current inputs, then compare after the edge.
   task automatic tick(input string tag);
      int ng, nt, ns, d;
      bit nsync, nramp, npend, beat, wt, ws, wc;
      ng = m_g; nt = m_t; ns = m_s;
      nsync = m_sync; nramp = m_ramp; npend = m_pend;
      beat = smp_tvalid && smp_tready;
      wt = set_stb && set_addr == 8'd192;
      ws = set_stb && set_addr == 8'd193;
      wc = set_stb && set_addr == 8'd194;
      d  = int'(set_data[15:0]);
      if (ws) ns = d;
      if (wc) nsync = set_data[0];
      if (wc && set_data[1]) begin
         nramp = 0; npend = 0; nt = m_g;
      end else if (m_ramp) begin
         if (beat) ng = toward(m_g, m_t, m_s);
         if (wt) nt = d;
         nramp = (ng != nt);
      end else if (m_pend) begin
         if (wt) nt = d;
         if (nt == m_g) npend = 0;
         else if (beat && smp_tlast) begin npend = 0; nramp = 1; end
      end else if (wt) begin
         nt = d;
         if (d != m_g) begin
            if (m_sync) npend = 1; else nramp = 1;
         end
      end
      @(posedge ce_clk);
      #1;
      m_g = ng; m_t = nt; m_s = ns;
      m_sync = nsync; m_ramp = nramp; m_pend = npend;
      check_outputs(tag);
   endtask

   task automatic sr_write(input logic [7:0] a, input logic [31:0] dat, input string tag);
      set_stb = 1'b1; set_addr = a; set_data = dat;
      tick(tag);
      set_stb = 1'b0; set_addr = '0; set_data = '0;
   endtask

   task automatic drive_beat(input bit v, input bit r, input bit l);
      smp_tvalid = v; smp_tready = r; smp_tlast = l;
   endtask

   initial begin
      logic [15:0] exp2 [4];
      logic [15:0] exp3 [6];
      int guard;
      exp2 = '{16'h0140, 16'h0180, 16'h01C0, 16'h0200};
      exp3 = '{16'h01D0, 16'h01A0, 16'h0170, 16'h0140, 16'h0110, 16'h0100};

      // Reset and idle
      model_reset();
      repeat (2) @(posedge ce_clk);
      #1 ce_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick("idle");
      chk("rst_gain", 64'(gain_out), 64'h0100);
      chk("rst_rb_lo", 64'(rb_data[15:0]), 64'h0100);

      // Upward ramp, beats every cycle with one stalled cycle
      sr_write(8'd193, 32'h40, "t2_step");
      sr_write(8'd194, 32'h0, "t2_ctrl");
      sr_write(8'd192, 32'h200, "t2_tgt");
      chk("t2_ramp_on", 64'(ramping), 64'h1);
      for (int i = 0; i < 4; i++) begin
         drive_beat(1, 1, 0);
         tick("t2_beat");
         chk("t2_gain_seq", 64'(gain_out), 64'(exp2[i]));
         if (i == 1) begin
            drive_beat(1, 0, 0);
            tick("t2_stall");
            chk("t2_hold", 64'(gain_out), 64'h0180);
         end
      end
      chk("t2_ramp_off", 64'(ramping), 64'h0);
      drive_beat(0, 0, 0);

      // Downward ramp with clamp at target
      sr_write(8'd193, 32'h30, "t3_step");
      sr_write(8'd192, 32'h100, "t3_tgt");
      for (int i = 0; i < 6; i++) begin
         drive_beat(1, 1, 0);
         tick("t3_beat");
         chk("t3_gain_seq", 64'(gain_out), 64'(exp3[i]));
      end
      drive_beat(1, 1, 0);
      tick("t3_extra");
      chk("t3_floor", 64'(gain_out), 64'h0100);
      drive_beat(0, 0, 0);

      // Packet-boundary start
      sr_write(8'd194, 32'h1, "t4_ctrl");
      sr_write(8'd192, 32'h300, "t4_tgt");
      chk("t4_pending", 64'(pending), 64'h1);
      for (int i = 0; i < 5; i++) begin
         drive_beat(1, 1, i == 4);
         tick("t4_beat");
         chk("t4_gain_hold", 64'(gain_out), 64'h0100);
      end
      chk("t4_ramp_start", 64'(ramping), 64'h1);
      drive_beat(1, 1, 0);
      tick("t4_first_step");
      chk("t4_step6", 64'(gain_out), 64'h0130);
      guard = 0;
      while (ramping && guard < 40) begin tick("t4_run"); guard++; end
      chk("t4_done", 64'(gain_out), 64'h0300);
      drive_beat(0, 0, 0);

      // Mid-ramp retarget reverses direction
      sr_write(8'd194, 32'h0, "t5_ctrl");
      sr_write(8'd193, 32'h80, "t5_step0");
      sr_write(8'd192, 32'h280, "t5_pre");
      drive_beat(1, 1, 0); tick("t5_pre_beat"); drive_beat(0, 0, 0);
      chk("t5_at_280", 64'(gain_out), 64'h0280);
      sr_write(8'd193, 32'h40, "t5_step");
      sr_write(8'd192, 32'h400, "t5_up");
      sr_write(8'd192, 32'h180, "t5_retgt");
      drive_beat(1, 1, 0); tick("t5_beat");
      chk("t5_reverse", 64'(gain_out), 64'h0240);

      // Abort freezes gain and target
      drive_beat(0, 0, 0);
      sr_write(8'd194, 32'h2, "t6_abort");
      chk("t6_idle", 64'(ramping), 64'h0);
      chk("t6_target", 64'(rb_data[31:16]), 64'h0240);
      drive_beat(1, 1, 0);
      repeat (3) tick("t6_hold");
      chk("t6_gain_frozen", 64'(gain_out), 64'h0240);
      drive_beat(0, 0, 0);

      // Asynchronous reset mid-ramp
      sr_write(8'd192, 32'h180, "t7_tgt");
      drive_beat(1, 1, 0); tick("t7_beat"); drive_beat(0, 0, 0);
      #3 ce_rst_n = 1'b0;
      #1;
      chk("t7_async_gain", 64'(gain_out), 64'h0100);
      chk("t7_async_ramp", 64'(ramping), 64'h0);
      model_reset();
      @(posedge ce_clk);
      #1 ce_rst_n = 1'b1;
      check_outputs("t7_post");

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int sel;
         drive_beat($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
         set_stb = ($urandom_range(0, 9) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 5) begin
            set_addr = 8'd192; set_data = $urandom;
         end else if (sel < 7) begin
            set_addr = 8'd193;
            set_data = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom_range(1, 16'h3000));
         end else if (sel < 9) begin
            set_addr = 8'd194;
            set_data = {30'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom)};
         end else begin
            set_addr = 8'($urandom); set_data = $urandom;
         end
         tick("rnd");
      end
      set_stb = 1'b0;
      drive_beat(0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gain_ramp_ctrl.md
Name: gain_ramp_ctrl

Overview:
- Sequences the gain coefficient driven into the gain block's real-by-complex multiplier (real_tdata input).
- Target gain and ramp step arrive on the noc_shell settings bus.
- Gain moves toward the target by a programmed step per accepted sample, so a gain change never produces a discontinuity.
- Optionally, the ramp starts only at a packet boundary.

Parameters:
- GAIN_WIDTH, 16, width of gain, target and step (unsigned).
- SR_TARGET, 192, settings address of target gain.
- SR_STEP, 193, settings address of ramp step.
- SR_CTRL, 194, settings address of control (bit0 = sync_on_eop, bit1 = abort).
- RESET_GAIN, 16'h0100, gain_out value after reset.

Ports:
- ce_clk, in, 1, compute-engine clock.
- ce_rst_n, in, 1, asynchronous active-low reset.
- set_stb, in, 1, settings strobe.
- set_addr, in, 8, settings address.
- set_data, in, 32, settings data; low GAIN_WIDTH bits used for target and step.
- smp_tvalid, in, 1, monitored sample-stream valid (multiplier input side).
- smp_tready, in, 1, monitored sample-stream ready.
- smp_tlast, in, 1, monitored sample-stream last.
- gain_out, out, GAIN_WIDTH, registered gain to multiplier.
- ramping, out, 1, high in RAMP state.
- pending, out, 1, high in PENDING state.
- rb_data, out, 64, {16'd0, step, target, gain_out}.

Behaviour:
- Reset (ce_rst_n low, asynchronous):
  - gain_out=RESET_GAIN, target=RESET_GAIN, step=0, sync_on_eop=0.
  - State IDLE; ramping=0, pending=0.
- beat = smp_tvalid & smp_tready. The block only observes the stream; it never drives the handshake.
- Register writes take effect on the cycle after set_stb with a matching address.
- Write to SR_STEP:
  - Updates step only.
  - A ramp in progress uses the new step from the next beat onward.
- Write to SR_CTRL:
  - Updates sync_on_eop.
  - bit1=1 (abort): state goes to IDLE, target := gain_out, gain_out frozen. The abort bit is self-clearing and is not stored.
- Write to SR_TARGET:
  - IDLE, sync_on_eop=1: target latched, go to PENDING.
  - IDLE, sync_on_eop=0: target latched, go to RAMP.
  - PENDING: target overwritten, remain PENDING.
  - RAMP: target overwritten (retarget), remain RAMP, direction re-evaluated on the next beat.
  - If the written target equals gain_out: stay or return to IDLE, no ramp.
- PENDING -> RAMP on the cycle after a beat with smp_tlast=1. That beat itself does not step gain.
- RAMP, on each beat:
  - If step==0: gain_out := target (jump).
  - If |target-gain_out| <= step: gain_out := target.
  - Otherwise gain_out := gain_out ± step toward target.
  - Never overshoot, never wrap. Arithmetic is computed at GAIN_WIDTH+1 bits.
  - When the new gain_out equals target, go to IDLE on the same edge.
- No beat: gain_out holds in every state.
- Latency: gain_out updates on the clock edge that samples the beat, so the change is visible in the cycle after the beat. This aligns the new gain with the next sample presented.
- Simultaneous events:
  - SR_TARGET write plus beat in RAMP: the step uses the old target; the new target is stored for subsequent beats.
  - SR_TARGET write plus tlast beat in PENDING: the new target is stored and the transition to RAMP still occurs.
  - Abort plus any other event: abort wins.
- Outputs: ramping and pending are decoded from registered state and are glitch-free. rb_data is registered.
- Reset mid-ramp: immediate return to reset values; no partial state survives.

Test Plan:
- Reset, then idle 10 cycles -> gain_out=16'h0100, ramping=0, pending=0, rb_data[15:0]=16'h0100.
- step=16'h0040, sync_on_eop=0, target=16'h0200, beats every cycle -> gain_out 0x0140, 0x0180, 0x01C0, 0x0200; ramping falls with the 4th beat; no change in cycles without a beat.
- step=16'h0030, target=16'h0100 from 0x0200 -> gain_out 0x01D0, 0x01A0, 0x0170, 0x0140, 0x0110, 0x0100 (clamped); never below 0x0100.
- sync_on_eop=1, target=16'h0300, 5 beats with tlast only on the 5th -> pending=1 and gain constant through the 5th beat; ramping starts the next cycle; the first step occurs on the 6th beat.
- Mid-ramp retarget 0x0400 -> 0x0180 while gain_out=0x0280, step=0x0040 -> the next beat gives 0x0240 (direction reverses) and the ramp continues down to 0x0180.
- Abort during RAMP at gain_out=0x0240 -> IDLE next cycle, target=0x0240, further beats hold the gain. Also: ce_rst_n pulse mid-ramp -> gain_out=0x0100 asynchronously.
